// File: rtl/rs_candidate_search_pkg.sv
// Shared constants for the sphere-decoder candidate search: 8-PSK symbol codes,
// sequencer state encoding and the metric-width helper.
package rs_candidate_search_pkg;

  localparam int NUM_SYM = 8;

  localparam logic [2:0] ROT_0   = 3'd7;
  localparam logic [2:0] ROT_45  = 3'd6;
  localparam logic [2:0] ROT_90  = 3'd2;
  localparam logic [2:0] ROT_135 = 3'd3;
  localparam logic [2:0] ROT_180 = 3'd1;
  localparam logic [2:0] ROT_225 = 3'd0;
  localparam logic [2:0] ROT_270 = 3'd4;
  localparam logic [2:0] ROT_315 = 3'd5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Two guard bits: sum of two (WIDTH+1)-bit magnitudes never wraps.
  function automatic int metric_width(input int width);
    return width + 2;
  endfunction

endpackage

// File: rtl/l1_metric.sv
// Combinational L1 distance |y - p| = |dr| + |di| between two complex samples.
module l1_metric
  import rs_candidate_search_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int MWIDTH = metric_width(WIDTH)
) (
  input  logic signed [WIDTH-1:0] y_real,
  input  logic signed [WIDTH-1:0] y_imag,
  input  logic signed [WIDTH-1:0] p_real,
  input  logic signed [WIDTH-1:0] p_imag,
  output logic [MWIDTH-1:0]       metric
);

  logic signed [WIDTH:0] dr, di;
  logic [WIDTH:0]        abs_r, abs_i;

  assign dr    = {y_real[WIDTH-1], y_real} - {p_real[WIDTH-1], p_real};
  assign di    = {y_imag[WIDTH-1], y_imag} - {p_imag[WIDTH-1], p_imag};
  assign abs_r = dr[WIDTH] ? $unsigned(-dr) : $unsigned(dr);
  assign abs_i = di[WIDTH] ? $unsigned(-di) : $unsigned(di);

  assign metric = MWIDTH'(abs_r) + MWIDTH'(abs_i);

endmodule

// File: rtl/rot_mult_8psk.sv
// Rotation multiplier: out = in * exp(j*angle(s)), diagonals scaled by 181/256.
// Diagonal terms are sign-adjusted before the scale so rounding is floor of the exact product.
module rot_mult_8psk
  import rs_candidate_search_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic [2:0]              s,
  input  logic signed [WIDTH-1:0] in_real,
  input  logic signed [WIDTH-1:0] in_imag,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag
);

  localparam int PW = WIDTH + 9;

  logic signed [WIDTH:0] a, b, sum, dif, pre_re, pre_im;
  logic signed [PW-1:0]  prod_re, prod_im;

  assign a   = {in_real[WIDTH-1], in_real};
  assign b   = {in_imag[WIDTH-1], in_imag};
  assign sum = a + b;
  assign dif = a - b;

  always_comb begin
    pre_re = dif;
    pre_im = sum;
    case (s)
      ROT_135: begin pre_re = -sum; pre_im = dif;  end
      ROT_225: begin pre_re = -dif; pre_im = -sum; end
      ROT_315: begin pre_re = sum;  pre_im = -dif; end
      default: ;
    endcase
  end

  assign prod_re = PW'(pre_re) * PW'(181);
  assign prod_im = PW'(pre_im) * PW'(181);

  always_comb begin
    out_real = WIDTH'(prod_re >>> 8);
    out_imag = WIDTH'(prod_im >>> 8);
    case (s)
      ROT_0:   begin out_real = in_real;  out_imag = in_imag;  end
      ROT_90:  begin out_real = -in_imag; out_imag = in_real;  end
      ROT_180: begin out_real = -in_real; out_imag = -in_imag; end
      ROT_270: begin out_real = in_imag;  out_imag = -in_real; end
      default: ;
    endcase
  end

endmodule

// File: rtl/rs_candidate_search.sv
// Sweeps all eight 8-PSK codes through one rotation multiplier and keeps the
// lowest-L1 candidate within the radius, plus a survivor count.
//
// state   | meaning
// IDLE    | waiting for start, operands captured on accept
// RUN     | one symbol code evaluated per cycle, cnt = code
// DONE    | result held until out_ready
module rs_candidate_search
  import rs_candidate_search_pkg::*;
#(
  parameter int WIDTH  = 20,
  parameter int MWIDTH = metric_width(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] R_real,
  input  logic signed [WIDTH-1:0] R_imag,
  input  logic signed [WIDTH-1:0] Y_real,
  input  logic signed [WIDTH-1:0] Y_imag,
  input  logic [MWIDTH-1:0]       radius,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2:0]              S_best,
  output logic [MWIDTH-1:0]       metric_best,
  output logic                    found,
  output logic [3:0]              n_survivors
);

  localparam logic signed [WIDTH-1:0] LIM = WIDTH'((1 << (WIDTH - 2)) - 1);

  logic [1:0]              state;
  logic [2:0]              cnt;
  logic signed [WIDTH-1:0] r_real_q, r_imag_q, y_real_q, y_imag_q;
  logic [MWIDTH-1:0]       radius_q;
  logic signed [WIDTH-1:0] rot_real, rot_imag;
  logic [MWIDTH-1:0]       m;
  logic                    hit, better;

  rot_mult_8psk #(.WIDTH(WIDTH)) u_rot (
    .s        (cnt),
    .in_real  (r_real_q),
    .in_imag  (r_imag_q),
    .out_real (rot_real),
    .out_imag (rot_imag)
  );

  l1_metric #(.WIDTH(WIDTH), .MWIDTH(MWIDTH)) u_l1 (
    .y_real (y_real_q),
    .y_imag (y_imag_q),
    .p_real (rot_real),
    .p_imag (rot_imag),
    .metric (m)
  );

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign hit       = (m <= radius_q);
  assign better    = hit && (m < metric_best);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      S_best      <= '0;
      metric_best <= '0;
      found       <= 1'b0;
      n_survivors <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          r_real_q    <= R_real;
          r_imag_q    <= R_imag;
          y_real_q    <= Y_real;
          y_imag_q    <= Y_imag;
          radius_q    <= radius;
          S_best      <= '0;
          metric_best <= '1;
          found       <= 1'b0;
          n_survivors <= '0;
          cnt         <= '0;
          state       <= ST_RUN;
        end
        ST_RUN: begin
          if (hit) n_survivors <= n_survivors + 4'd1;
          // Strict compare: on a tie the earlier (lower) code stays.
          if (better) begin
            S_best      <= cnt;
            metric_best <= m;
            found       <= 1'b1;
          end
          cnt <= cnt + 3'd1;
          if (cnt == 3'(NUM_SYM - 1)) state <= ST_DONE;
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  function automatic logic in_range(input logic signed [WIDTH-1:0] v);
    return (v <= LIM) && (v >= -LIM);
  endfunction

  // Operands beyond +/-(2^(WIDTH-2)-1) would overflow the multiplier.
  always_ff @(posedge clk) begin
    if (!rst && in_ready && start)
      assert (in_range(R_real) && in_range(R_imag) && in_range(Y_real) && in_range(Y_imag));
  end

endmodule

// File: doc/rs_candidate_search.md
Name: rs_candidate_search

Overview:
- Sequencer for the 8-PSK rotation multiplier in the L1-norm sphere decoder.
- For one tree node, sweeps all eight symbol codes S through a single rotation-multiplier instance, one per cycle.
- Each cycle it forms the L1 metric |Y - R*s| and keeps the best candidate within the search radius.
- Sits between the node-expansion controller (start/result handshake) and the shared rotation datapath.

Parameters:
- WIDTH, 20, signed width of R, Y and the multiplier outputs.
- MWIDTH, WIDTH+2, unsigned metric and radius width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a search; accepted only when in_ready=1
- in_ready  out  1  high in IDLE only
- R_real  in  WIDTH  signed channel coefficient, real part; sampled on accept
- R_imag  in  WIDTH  signed channel coefficient, imaginary part; sampled on accept
- Y_real  in  WIDTH  signed residual target, real part; sampled on accept
- Y_imag  in  WIDTH  signed residual target, imaginary part; sampled on accept
- radius  in  MWIDTH  pruning bound (inclusive); sampled on accept
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- S_best  out  3  winning symbol code
- metric_best  out  MWIDTH  winning L1 metric
- found  out  1  at least one candidate had metric <= radius
- n_survivors  out  4  count of candidates with metric <= radius (0..8)

Behaviour:
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On start, register R, Y and radius; clear best to (S=0, metric=all-ones, found=0); clear n_survivors; set cnt=0; go to RUN. Acceptance cycle is T.
- RUN, cycles T+1..T+8:
  - Multiplier S input is cnt; its outputs are combinational.
  - dr = Y_real - Out_real and di = Y_imag - Out_imag, each sign-extended to WIDTH+1 bits.
  - m = |dr| + |di| in MWIDTH bits, with no saturation.
  - If m <= radius, increment n_survivors.
  - If m <= radius and m < current best metric (strict), update best to (cnt, m) and set found=1.
  - Ties therefore keep the lower S. cnt increments each cycle.
  - After cnt=7 is evaluated, go to DONE.
- DONE: out_valid=1 from T+9. Outputs hold stable until the cycle where out_valid and out_ready are both high, then go to IDLE. No new start is accepted in the same cycle.
- Latency: accept to out_valid is 9 cycles; back-to-back throughput is 1 search per 10 cycles.
- Result when found=0: S_best=0, metric_best=all-ones.
- start outside IDLE is ignored. Inputs change freely after the acceptance cycle.
- Input range contract: R and Y must lie within ±(2^(WIDTH-2)-1), so the multiplier's negation and ×181 stay in range. Behaviour outside this range is unspecified; add an assertion.
- Reset: takes effect in any state, including mid-RUN and DONE, and discards the search in progress. Next cycle values:
  - state=IDLE, in_ready=1, out_valid=0
  - S_best=0, metric_best=0, found=0, n_survivors=0, cnt=0

Decomposition:
- Shared package holds:
  - symbol-code constants: ROT_0=7, ROT_45=6, ROT_90=2, ROT_135=3, ROT_180=1, ROT_225=0, ROT_270=4, ROT_315=5
  - NUM_SYM=8
  - FSM state encoding
  - metric-width helper
- Instantiates the existing rotation multiplier unchanged.
- One natural new sub-module: l1_metric (combinational difference, absolute value and sum). It is reused by later norm blocks.

Test Plan:
- R=(256,0), Y=(0,256), radius=1000 -> S_best=2, metric_best=0, found=1; out_valid exactly 9 cycles after accept.
- R=(256,0), Y=(181,181), radius=1000 -> S_best=6 (multiplier gives (181,181)), metric_best=0; S=7 gives metric 256.
- R=(0,0), Y=(10,-5), radius=100 -> all metrics 15, S_best=0 by tie rule, n_survivors=8.
- R=(256,0), Y=(5000,5000), radius=10 -> found=0, S_best=0, metric_best=all-ones, n_survivors=0.
- Complete a search, hold out_ready=0 for 5 cycles with start pulsed -> outputs stable, in_ready=0, start ignored; out_ready=1 -> IDLE next cycle, new start accepted.
- Assert rst at T+4 mid-RUN -> next cycle IDLE, out_valid=0, all outputs zero; a fresh search then completes with correct results.
